// File: rtl/crc32_fcs_ctrl.sv
// Frame sequencer for the byte-wide CRC-32 engine: passes payload through, zero-pads
// short frames, appends the 4 FCS bytes and holds off the next frame for the gap.
module crc32_fcs_ctrl #(
  parameter int DATA_W     = 8,
  parameter int MIN_LEN    = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              crc_init,
  output logic              crc_calc,
  output logic              crc_d_valid,
  output logic [DATA_W-1:0] crc_d,
  input  logic [DATA_W-1:0] crc_byte,
  output logic              frame_done,
  output logic [15:0]       frame_len
);

  typedef enum logic [2:0] {IDLE, DATA, PAD, FCS, GAP} state_t;

  localparam logic [16:0] MIN_LEN_W = 17'(MIN_LEN);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  fcs_idx, fcs_idx_nxt;
  logic [15:0] gap_cnt, gap_cnt_nxt;
  logic        frame_done_nxt;
  logic [15:0] frame_len_nxt;
  logic        reaches_min;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] sat_add4(input logic [15:0] v);
    logic [16:0] s;
    s = {1'b0, v} + 17'd4;
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Compared unsaturated so a saturated counter can never fall back under MIN_LEN.
  assign reaches_min = ({1'b0, cnt} + 17'd1) >= MIN_LEN_W;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    fcs_idx_nxt    = fcs_idx;
    gap_cnt_nxt    = gap_cnt;
    frame_done_nxt = 1'b0;
    frame_len_nxt  = frame_len;
    s_ready        = 1'b0;
    m_valid        = 1'b0;
    m_data         = '0;
    m_last         = 1'b0;
    crc_init       = 1'b0;
    crc_calc       = 1'b0;
    crc_d_valid    = 1'b0;
    crc_d          = '0;
    case (state)
      IDLE: begin
        crc_init = 1'b1;
        if (s_valid) state_nxt = DATA;
      end
      DATA: begin
        m_data  = s_data;
        m_valid = s_valid;
        s_ready = m_ready;
        crc_d   = s_data;
        if (s_valid && m_ready) begin
          crc_d_valid = 1'b1;
          crc_calc    = 1'b1;
          cnt_nxt     = sat_inc(cnt);
          if (s_last) state_nxt = reaches_min ? FCS : PAD;
        end
      end
      PAD: begin
        m_valid = 1'b1;
        if (m_ready) begin
          crc_d_valid = 1'b1;
          crc_calc    = 1'b1;
          cnt_nxt     = sat_inc(cnt);
          if (reaches_min) state_nxt = FCS;
        end
      end
      FCS: begin
        // Engine already holds the final CRC, so its MS byte is valid on the first FCS cycle.
        m_data  = crc_byte;
        m_valid = 1'b1;
        m_last  = (fcs_idx == 2'd3);
        if (m_ready) begin
          crc_d_valid = 1'b1;
          fcs_idx_nxt = fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            frame_done_nxt = 1'b1;
            frame_len_nxt  = sat_add4(cnt);
            cnt_nxt        = '0;
            fcs_idx_nxt    = '0;
            gap_cnt_nxt    = '0;
            state_nxt      = (IFG_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        crc_init = 1'b1;
        if (gap_cnt == IFG_LAST) begin
          gap_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // While reset is held the frame is already dead: present idle handshakes immediately.
    if (reset) begin
      s_ready     = 1'b0;
      m_valid     = 1'b0;
      m_last      = 1'b0;
      crc_init    = 1'b1;
      crc_calc    = 1'b0;
      crc_d_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      fcs_idx    <= '0;
      gap_cnt    <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      fcs_idx    <= fcs_idx_nxt;
      gap_cnt    <= gap_cnt_nxt;
      frame_done <= frame_done_nxt;
      frame_len  <= frame_len_nxt;
    end
  end

endmodule
